// File: rtl/board_tile_scheduler_if.sv
// Tile write port from game logic to board_tile_scheduler (valid/ready, one tile per beat).
interface board_tile_scheduler_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_addr;
  logic [3:0] wr_state;
  logic       wr_last;

  modport master (output wr_valid, wr_addr, wr_state, wr_last, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_state, wr_last, output wr_ready);
endinterface

// File: rtl/board_tile_scheduler.sv
// Scans the 4x4 board for the shared tile renderer. With BOARD_SCHED_VBLANK_COMMIT_EN
// defined, game writes land in a shadow board and are committed at the start of vblank.
module board_tile_scheduler #(
  parameter int unsigned X0       = 96,
  parameter int unsigned Y0       = 16,
  parameter int unsigned PITCH    = 112,
  parameter int unsigned TILE     = 106,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           h_cnt,
  input  logic [11:0]           v_cnt,
  board_tile_scheduler_if.slave wr,
  output logic [3:0]            tile_state,
  output logic [11:0]           tile_h,
  output logic [11:0]           tile_v,
  output logic                  in_tile,
  output logic                  commit_pending
);
  localparam int unsigned CW = 12;
  localparam logic [CW-1:0] X0_C       = CW'(X0);
  localparam logic [CW-1:0] X_END_C    = CW'(X0 + 4 * PITCH - 1);
  localparam logic [CW-1:0] Y0_C       = CW'(Y0);
  localparam logic [CW-1:0] Y_END_C    = CW'(Y0 + 4 * PITCH - 1);
  localparam logic [CW-1:0] PITCH_M1_C = CW'(PITCH - 1);
  localparam logic [CW-1:0] TILE_C     = CW'(TILE);

  logic              ready_q;
  logic [15:0][3:0]  disp_q, disp_d;
  logic [1:0]        col_q, col_d, row_q, row_d;
  logic [CW-1:0]     xoff_q, xoff_d, yoff_q, yoff_d;
  logic              v_live_q, v_live_d;
  logic              in_tile_q, in_tile_d;
  logic [3:0]        tile_state_q, tile_state_d;
  logic [CW-1:0]     tile_h_q, tile_h_d, tile_v_q, tile_v_d;
  logic              h_live_c;
  logic              accept_c;

`ifdef BOARD_SCHED_VBLANK_COMMIT_EN
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);

  logic [15:0][3:0]  shadow_q, shadow_d;
  logic              pend_q, pend_d;
  logic              commit_c;

  assign commit_c    = pend_q && (v_cnt == V_ACT_C) && (h_cnt == '0);
  assign wr.wr_ready = ready_q && !commit_c;
  assign commit_pending = pend_q;
`else
  logic unused_last_c;

  assign unused_last_c  = wr.wr_last;
  assign wr.wr_ready    = ready_q;
  assign commit_pending = 1'b0;
`endif

  assign accept_c = wr.wr_valid && wr.wr_ready;

  // Board storage: commit copies the whole shadow in one cycle; writes never coincide with it.
  always_comb begin
    disp_d = disp_q;
`ifdef BOARD_SCHED_VBLANK_COMMIT_EN
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (commit_c) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
    if (accept_c) begin
      shadow_d[wr.wr_addr] = wr.wr_state;
      if (wr.wr_last) pend_d = 1'b1;
    end
`else
    if (accept_c) disp_d[wr.wr_addr] = wr.wr_state;
`endif
  end

  // Scan position for the pixel on h_cnt/v_cnt; outputs are registered from it.
  always_comb begin
    col_d    = col_q;
    xoff_d   = xoff_q + 12'd1;
    row_d    = row_q;
    yoff_d   = yoff_q;
    v_live_d = v_live_q;
    if (h_cnt == X0_C) begin
      col_d  = '0;
      xoff_d = '0;
    end else if (xoff_q == PITCH_M1_C) begin
      col_d  = col_q + 2'd1;
      xoff_d = '0;
    end
    if (h_cnt == '0) begin
      v_live_d = (v_cnt >= Y0_C) && (v_cnt <= Y_END_C);
      if (v_cnt == Y0_C) begin
        row_d  = '0;
        yoff_d = '0;
      end else if (yoff_q == PITCH_M1_C) begin
        row_d  = row_q + 2'd1;
        yoff_d = '0;
      end else begin
        yoff_d = yoff_q + 12'd1;
      end
    end
    h_live_c     = (h_cnt >= X0_C) && (h_cnt <= X_END_C);
    in_tile_d    = h_live_c && v_live_d && (xoff_d < TILE_C) && (yoff_d < TILE_C);
    tile_state_d = '0;
    tile_h_d     = '0;
    tile_v_d     = '0;
    if (in_tile_d) begin
      tile_state_d = disp_q[{row_d, col_d}];
      tile_h_d     = xoff_d;
      tile_v_d     = yoff_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q      <= 1'b0;
      disp_q       <= '0;
      col_q        <= '0;
      xoff_q       <= '0;
      row_q        <= '0;
      yoff_q       <= '0;
      v_live_q     <= 1'b0;
      in_tile_q    <= 1'b0;
      tile_state_q <= '0;
      tile_h_q     <= '0;
      tile_v_q     <= '0;
`ifdef BOARD_SCHED_VBLANK_COMMIT_EN
      shadow_q     <= '0;
      pend_q       <= 1'b0;
`endif
    end else begin
      ready_q      <= 1'b1;
      disp_q       <= disp_d;
      col_q        <= col_d;
      xoff_q       <= xoff_d;
      row_q        <= row_d;
      yoff_q       <= yoff_d;
      v_live_q     <= v_live_d;
      in_tile_q    <= in_tile_d;
      tile_state_q <= tile_state_d;
      tile_h_q     <= tile_h_d;
      tile_v_q     <= tile_v_d;
`ifdef BOARD_SCHED_VBLANK_COMMIT_EN
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
`endif
    end
  end

  assign tile_state = tile_state_q;
  assign tile_h     = tile_h_q;
  assign tile_v     = tile_v_q;
  assign in_tile    = in_tile_q;
endmodule

// File: doc/board_tile_scheduler.md
# board_tile_scheduler

Scans the 4×4 game board for the VGA pipeline. Holds the 16 tile codes (4-bit exponent states, same encoding as the tile renderer, 0 = empty) and accepts updates from game logic through a valid/ready port. From the incoming `h_cnt`/`v_cnt`, it presents the single shared tile renderer with the current tile's state and tile-local pixel coordinates. Game-logic updates are double-buffered and committed only during vertical blanking, so a move never tears mid-frame.

## Interface
- `X0`, 96: first active pixel column of the board.
- `Y0`, 16: first active line of the board.
- `PITCH`, 112: tile-to-tile spacing in pixels, both axes.
- `TILE`, 106: drawn tile size in pixels; must be less than `PITCH`.
- `V_ACTIVE`, 480: first vertical blanking line.
- `clk` in 1: pixel clock. `h_cnt` advances by 1 per cycle within a line.
- `rst` in 1: asynchronous reset, active-high.
- `h_cnt` in 12: horizontal pixel counter.
- `v_cnt` in 12: vertical line counter.
- `wr_valid` in 1: tile write request.
- `wr_ready` out 1: write accepted on a cycle where `wr_valid && wr_ready`.
- `wr_addr` in 4: tile index, {row[1:0], col[1:0]}, row 0 at top.
- `wr_state` in 4: new tile code.
- `wr_last` in 1: marks the final write of a move. Sampled with the accepted beat.
- `tile_state` out 4: code of the tile under the current pixel. 0 when outside a tile.
- `tile_h` out 12: pixel column inside the tile, 0..`TILE`-1.
- `tile_v` out 12: pixel line inside the tile, 0..`TILE`-1.
- `in_tile` out 1: current pixel lies inside a drawn tile.
- `commit_pending` out 1: a completed move is waiting for blanking.

## Operation
- **Storage**
  - `shadow[16]` is written by accepted beats.
  - `disp[16]` is read by the scan logic.
  - Both reset to 0.
- **Write port**
  - `wr_ready` = 1 except in reset and on the commit cycle.
  - An accepted beat writes `shadow[wr_addr]`.
  - An accepted beat with `wr_last` = 1 sets `commit_pending`.
  - Repeated writes to the same address: the last accepted beat wins.
- **Commit**
  - Fires on the cycle where `v_cnt == V_ACTIVE && h_cnt == 0 && commit_pending`.
  - Copies all 16 `shadow` entries into `disp` in that single cycle.
  - Clears `commit_pending`.
  - Drives `wr_ready` = 0 for that cycle only.
  - If `commit_pending` is not set at that point, `disp` is unchanged and the next blanking is awaited.
- **Column scan**
  - Registers `col` (2 bits) and `xoff` (12 bits).
  - At `h_cnt == X0`: `col`=0, `xoff`=0.
  - Afterwards `xoff` increments each cycle and wraps at `PITCH`-1; `col` increments on each wrap.
  - Horizontal region is live from `X0` to `X0`+4·`PITCH`-1.
- **Row scan**
  - Registers `row` and `yoff`, updated once per line at `h_cnt == 0`.
  - At `v_cnt == Y0`: reset to 0.
  - Otherwise `yoff` increments and wraps at `PITCH`-1; `row` increments on each wrap.
  - Vertical region is live from `Y0` to `Y0`+4·`PITCH`-1.
- **Tile select**
  - `in_tile` = both regions live && `xoff < TILE` && `yoff < TILE`.
  - When `in_tile`: `tile_state` = `disp[{row,col}]`, `tile_h` = `xoff`, `tile_v` = `yoff`.
  - Otherwise all three outputs are 0.
- **Widths:** all offset comparisons are unsigned 12-bit. `col`/`row` saturate logically, because the region flag gates them.

## Timing
- Scan outputs are registered one cycle after the `h_cnt`/`v_cnt` they describe. The downstream renderer delays its counters by 1 to match.
- **Reset values**
  - `wr_ready`=0, `tile_state`=0, `tile_h`=0, `tile_v`=0, `in_tile`=0, `commit_pending`=0.
  - Scan registers are cleared.
  - `wr_ready` rises on the first clock after `rst` deasserts.
- **Write and commit on the same cycle:** `wr_ready`=0, so the beat is not taken. The master holds it, and it is accepted the next cycle into `shadow`.
- **`wr_last` arriving after the commit point:** waits for the next frame's blanking.
- **Reset mid-move:** both buffers clear. A partially written move is discarded.
- **Write latency:** a write becomes visible on screen no earlier than the first active line after the commit.

## Configuration
- Macro `BOARD_SCHED_VBLANK_COMMIT_EN`.
- **Defined:** double-buffered behaviour as above.
- **Undefined:**
  - `shadow` is removed; accepted beats write `disp` directly.
  - `wr_last` is ignored, and `commit_pending` is tied to 0.
  - `wr_ready` = 1 whenever not in reset.
  - Tearing is permitted.

## Test plan
- **Reset:** assert `rst` mid-line → all outputs 0 within the same cycle; `wr_ready` goes 1 one clock after release.
- **Deferred commit:** write addr 5 = 4'd3 with `wr_last`=1 at `v_cnt`=100 → `commit_pending`=1; pixels of tile 5 show 0 until `v_cnt`=480/`h_cnt`=0; from the next frame, `tile_state`=3 at `h_cnt`=X0+112+1, `v_cnt`=Y0+112.
- **Scan geometry:** `disp` all = 4'd1, sweep one line at `v_cnt`=Y0 → `in_tile`=1 for 106 cycles, then 0 for 6 cycles, repeating 4×; `tile_h` ramps 0..105; outside the board all outputs are 0.
- **Commit collision:** `wr_valid` held during the commit cycle → `wr_ready`=0 that cycle; beat accepted the next cycle and lands in `shadow` only.
- **Multi-beat move:** 3 beats with `wr_last` only on the third, issued before blanking → all three tiles change in the same frame.
- **Macro undefined:** write at `v_cnt`=200 → `tile_state` reflects the new value on the next scan of that tile in the same frame.
